fft_result_sink: RTL and testbench
==================================

Name: fft_result_sink

Overview:
Avalon-ST receiver for the FFT core's source interface. It drives source_ready back to the FFT and checks sop/eop framing. It converts each complex output bin to a 9-bit magnitude approximation, |re|+|im|, and stores one complete frame in an internal buffer. A downstream reader (the MCU-facing logic) then drains the frame sequentially, one bin per request.

Parameters:
FFT_N, 1024, points per frame; power of two, at least 4
DATA_W, 8, width of src_real/src_imag (two's complement)
EXP_W, 6, width of the FFT block exponent

Ports:
Clk  in  1  system clock; same clock as the FFT core
Reset_n  in  1  asynchronous, active-low reset
src_valid  in  1  FFT source_valid
src_sop  in  1  FFT source_sop
src_eop  in  1  FFT source_eop
src_real  in  DATA_W  FFT source_real, signed
src_imag  in  DATA_W  FFT source_imag, signed
src_exp  in  EXP_W  FFT source_exp, signed
src_error  in  2  FFT source_error
src_ready  out  1  FFT source_ready, registered
frame_rdy  out  1  complete frame held, ready to read
frame_exp  out  EXP_W  src_exp latched on the frame's sop beat
frame_err  out  1  one-cycle pulse on a framing or error violation
rd_req  in  1  read request, one bin per cycle
rd_data  out  DATA_W+1  magnitude of the current bin
rd_valid  out  1  rd_data valid
rd_last  out  1  rd_data is bin FFT_N-1

Behaviour:
- Beat acceptance: a beat is accepted when src_valid && src_ready are both 1 in the same cycle (ready latency 0).
- Magnitude, combinational on each accepted beat: mag = |src_real| + |src_imag|.
  - Each absolute value is DATA_W+1 bits wide, so -128 gives 128.
  - The sum saturates at 2^(DATA_W+1)-1; for DATA_W=8 that is 511, so (-128,-128) stores 256 without saturating.
- Storage: inferred synchronous RAM, FFT_N x (DATA_W+1). The write happens in the same cycle as the accepted beat, at address wr_idx.
- Reset values: state=IDLE, src_ready=1, frame_rdy=0, frame_exp=0, frame_err=0, rd_data=0, rd_valid=0, rd_last=0, wr_idx=0, rd_idx=0.
- Reset mid-frame: any partial frame or held frame is discarded with no frame_err pulse. RAM contents are don't-care after reset.
- State IDLE (src_ready=1):
  - Accepted beat with sop=1, eop=0, src_error=0: write bin 0, latch frame_exp, wr_idx<=1, go to CAPT.
  - Accepted beat without sop: silently dropped, stay in IDLE.
  - Beat with sop=1 and eop=1: frame_err pulse, stay in IDLE.
  - Beat with sop=1 and src_error!=0: frame_err pulse, stay in IDLE.
- State CAPT (src_ready=1). Checks are applied in this priority order:
  1. src_error!=0: frame_err pulse, go to IDLE.
  2. sop=1: restart the frame; write bin 0, latch frame_exp, wr_idx<=1, frame_err pulse.
  3. eop=1 and wr_idx==FFT_N-1: write, go to HOLD; frame_rdy<=1 and src_ready<=0 on the next edge.
  4. eop=1 and wr_idx!=FFT_N-1 (early eop): frame_err pulse, go to IDLE.
  5. eop=0 and wr_idx==FFT_N-1 (missing eop): frame_err pulse, go to IDLE.
  6. Otherwise: write, wr_idx++.
- State HOLD (src_ready=0, frame_rdy=1):
  - rd_req=1: read RAM at rd_idx; the next cycle has rd_valid=1 and rd_data=mem[rd_idx], then rd_idx++.
  - Throughput is one bin per cycle with back-to-back requests.
  - rd_last=1 together with rd_valid for bin FFT_N-1.
  - In the cycle the last request is issued, frame_rdy<=0, rd_idx<=0 and the state goes to IDLE; src_ready rises on the following edge.
  - rd_req is ignored while frame_rdy=0.
- rd_valid and rd_last are one-cycle pulses per read.
- frame_exp holds its value until the next sop is accepted.
- frame_err is registered and asserts for exactly one cycle per violation.

Test Plan:
- Good frame (FFT_N=8): stream 8 beats with re=k, im=-k (k=0..7), sop on beat 0, eop on beat 7, src_exp=-3. Required: frame_rdy=1 one cycle after the eop beat; src_ready=0; frame_exp=-3. Eight rd_req cycles return 0,2,4,...,14 with rd_last on the 8th; frame_rdy then clears and src_ready returns to 1.
- Extremes: beat with re=-128, im=-128 → stored magnitude 256; beat with re=127, im=-128 → 255.
- Early eop on beat 4 → one frame_err pulse, state IDLE, frame_rdy stays 0. A following good frame is captured correctly.
- Sop re-asserted on beat 3 of a frame → frame_err pulse; that beat becomes bin 0; the frame completes with eop 8 beats later.
- Backpressure: drive src_valid continuously while in HOLD → no beats written and the held data is unchanged on readback.
- Assert Reset_n low during CAPT and again during HOLD readout → all outputs return to reset values; no frame_err pulse; the next frame is captured cleanly.

Source files
------------

// File: rtl/fft_result_sink.sv
// Avalon-ST sink for the FFT source port: checks sop/eop framing, stores |re|+|im|
// per bin for one frame, then lets a downstream reader drain it one bin per request.
module fft_result_sink #(
    parameter int unsigned FFT_N  = 1024,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned EXP_W  = 6
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              src_valid,
    input  logic              src_sop,
    input  logic              src_eop,
    input  logic [DATA_W-1:0] src_real,
    input  logic [DATA_W-1:0] src_imag,
    input  logic [EXP_W-1:0]  src_exp,
    input  logic [1:0]        src_error,
    output logic              src_ready,
    output logic              frame_rdy,
    output logic [EXP_W-1:0]  frame_exp,
    output logic              frame_err,
    input  logic              rd_req,
    output logic [DATA_W:0]   rd_data,
    output logic              rd_valid,
    output logic              rd_last
);

    localparam int unsigned AW = $clog2(FFT_N);
    localparam int unsigned MW = DATA_W + 1;

    typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   wr_idx, rd_idx, wr_addr;
    logic            accept, wr_last, rd_idx_last;
    logic            wr_en, wr_restart, err_set, rd_fire;
    logic [MW-1:0]   abs_re, abs_im, mag;
    logic [MW:0]     mag_sum;
    logic [MW-1:0]   mem [FFT_N];

    // Sign-extend by one bit first so the most negative input has a representable magnitude.
    function automatic logic [MW-1:0] abs_ext(input logic [DATA_W-1:0] v);
        logic [MW-1:0] x;
        x = {v[DATA_W-1], v};
        return x[MW-1] ? ((~x) + MW'(1)) : x;
    endfunction

    assign accept      = src_valid && src_ready;
    assign wr_last     = (wr_idx == AW'(FFT_N - 1));
    assign rd_idx_last = (rd_idx == AW'(FFT_N - 1));
    assign abs_re      = abs_ext(src_real);
    assign abs_im      = abs_ext(src_imag);
    assign mag_sum     = {1'b0, abs_re} + {1'b0, abs_im};
    assign mag         = mag_sum[MW] ? '1 : mag_sum[MW-1:0];
    assign wr_addr     = wr_restart ? '0 : wr_idx;

    always_comb begin
        state_next = state;
        wr_en      = 1'b0;
        wr_restart = 1'b0;
        err_set    = 1'b0;
        rd_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && src_sop) begin
                    if (src_eop || src_error != '0) begin
                        err_set = 1'b1;
                    end else begin
                        wr_en      = 1'b1;
                        wr_restart = 1'b1;
                        state_next = CAPT;
                    end
                end
            end
            CAPT: begin
                if (accept) begin
                    if (src_error != '0) begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end else if (src_sop) begin
                        wr_en      = 1'b1;
                        wr_restart = 1'b1;
                        err_set    = 1'b1;
                    end else if (src_eop && wr_last) begin
                        wr_en      = 1'b1;
                        state_next = HOLD;
                    end else if (src_eop || wr_last) begin
                        err_set    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (rd_req) begin
                    rd_fire = 1'b1;
                    if (rd_idx_last) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            src_ready <= 1'b1;
            frame_rdy <= 1'b0;
            frame_exp <= '0;
            frame_err <= 1'b0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            wr_idx    <= '0;
            rd_idx    <= '0;
        end else begin
            state     <= state_next;
            // Stays low for one extra cycle after leaving HOLD.
            src_ready <= (state != HOLD) && (state_next != HOLD);
            frame_rdy <= (state_next == HOLD);
            frame_err <= err_set;
            rd_valid  <= rd_fire;
            rd_last   <= rd_fire && rd_idx_last;
            if (wr_en && wr_restart) frame_exp <= src_exp;
            if (state_next != CAPT)  wr_idx <= '0;
            else if (wr_en)          wr_idx <= wr_restart ? AW'(1) : wr_idx + AW'(1);
            if (rd_fire)             rd_idx <= rd_idx_last ? '0 : rd_idx + AW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)     rd_data <= '0;
        else if (rd_fire) rd_data <= mem[rd_idx];
    end

    always_ff @(posedge Clk) begin
        if (wr_en) mem[wr_addr] <= mag;
    end

endmodule

// File: tb/tb_fft_result_sink.sv
// Self-checking bench for fft_result_sink with FFT_N=8: framing, magnitudes,
// backpressure in HOLD and reset mid-frame, with a read-data scoreboard.
module tb_fft_result_sink;

    localparam int N  = 8;
    localparam int DW = 8;
    localparam int EW = 6;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0;
    logic [DW-1:0] src_real = '0, src_imag = '0;
    logic [EW-1:0] src_exp = '0;
    logic [1:0]    src_error = '0;
    logic          src_ready, frame_rdy, frame_err;
    logic [EW-1:0] frame_exp;
    logic          rd_req = 1'b0;
    logic [DW:0]   rd_data;
    logic          rd_valid, rd_last;

    fft_result_sink #(.FFT_N(N), .DATA_W(DW), .EXP_W(EW)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .src_valid(src_valid), .src_sop(src_sop), .src_eop(src_eop),
        .src_real(src_real), .src_imag(src_imag), .src_exp(src_exp),
        .src_error(src_error), .src_ready(src_ready),
        .frame_rdy(frame_rdy), .frame_exp(frame_exp), .frame_err(frame_err),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last)
    );

    always #5 Clk = ~Clk;

    typedef struct { int mag; bit last; } rd_exp_t;
    typedef struct { int re; int im; int mag; } vec_t;

    int      checks = 0;
    int      errors = 0;
    rd_exp_t sb[$];
    int      pend[$];
    vec_t    tbl[8];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Read-side scoreboard: every rd_valid pops one expected bin.
    always @(negedge Clk) begin : monitor
        rd_exp_t e;
        if (rd_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got rd_valid=1 expected no read data");
            end else begin
                e = sb.pop_front();
                check("rd_data", int'(rd_data), e.mag);
                check("rd_last", int'(rd_last), int'(e.last));
            end
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic beat(input int re, input int im, input bit sop, input bit eop,
                        input logic [1:0] er, input int ex, input int mag);
        src_valid = 1'b1;
        src_sop   = sop;
        src_eop   = eop;
        src_real  = DW'(re);
        src_imag  = DW'(im);
        src_error = er;
        src_exp   = EW'(ex);
        if (sop) pend.delete();
        pend.push_back(mag);
        step();
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
        src_error = '0;
    endtask

    task automatic commit();
        foreach (pend[i]) sb.push_back('{pend[i], i == pend.size() - 1});
        pend.delete();
    endtask

    task automatic read_n(input int n);
        rd_req = 1'b1;
        repeat (n) step();
        rd_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_src_ready"}, int'(src_ready), 1);
        check({tag, "_frame_rdy"}, int'(frame_rdy), 0);
        check({tag, "_frame_exp"}, int'(frame_exp), 0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_rd_data"},   int'(rd_data),   0);
        check({tag, "_rd_valid"},  int'(rd_valid),  0);
        check({tag, "_rd_last"},   int'(rd_last),   0);
    endtask

    // Ramp frame: re=k+off, im=-k gives magnitude 2k+|off| for off>=0.
    task automatic good_frame(input int off, input int ex);
        for (int k = 0; k < N; k++) beat(k + off, -k, k == 0, k == N - 1, 2'b00, ex, 2 * k + off);
        check("good_frame_rdy", int'(frame_rdy), 1);
        check("good_frame_src_ready", int'(src_ready), 0);
        check("good_frame_exp", int'(frame_exp), ex & 63);
        commit();
    endtask

    task automatic drain();
        read_n(N);
        check("drain_frame_rdy", int'(frame_rdy), 0);
        check("drain_src_ready_low", int'(src_ready), 0);
        step();
        check("drain_src_ready_high", int'(src_ready), 1);
    endtask

    initial begin
        tbl = '{'{-128, -128, 256}, '{127, -128, 255}, '{0, 0, 0}, '{-1, 1, 2},
                '{127, 127, 254}, '{-128, 0, 128}, '{5, -3, 8}, '{-7, -9, 16}};

        #1 Reset_n = 1'b0;
        #11;
        check_reset_outputs("reset");
        step();
        Reset_n = 1'b1;
        step();

        // Good ramp frame, exponent -3
        good_frame(0, -3);
        drain();

        // Magnitude extremes from the table
        for (int i = 0; i < N; i++)
            beat(tbl[i].re, tbl[i].im, i == 0, i == N - 1, 2'b00, 5, tbl[i].mag);
        check("ext_frame_rdy", int'(frame_rdy), 1);
        check("ext_frame_exp", int'(frame_exp), 5);
        commit();
        drain();

        // Early eop on beat 4
        for (int k = 0; k < 5; k++) beat(k, 0, k == 0, k == 4, 2'b00, 2, k);
        check("early_eop_err", int'(frame_err), 1);
        step();
        check("early_eop_err_pulse", int'(frame_err), 0);
        check("early_eop_frame_rdy", int'(frame_rdy), 0);
        good_frame(10, 1);
        drain();

        // Sop re-asserted on beat 3 restarts the frame at bin 0
        for (int k = 0; k < 3; k++) beat(k, 0, k == 0, 1'b0, 2'b00, 4, k);
        for (int j = 0; j < N; j++) begin
            beat(20 + j, -j, j == 0, j == N - 1, 2'b00, -7, 20 + 2 * j);
            if (j == 0) check("restart_err", int'(frame_err), 1);
            if (j == 1) check("restart_err_pulse", int'(frame_err), 0);
        end
        check("restart_frame_rdy", int'(frame_rdy), 1);
        check("restart_frame_exp", int'(frame_exp), (-7) & 63);
        commit();
        drain();

        // Framing violations from IDLE and CAPT; stray beat without sop is dropped
        beat(1, 1, 1'b1, 1'b1, 2'b00, 0, 0);
        check("idle_sop_eop_err", int'(frame_err), 1);
        beat(1, 1, 1'b1, 1'b0, 2'b01, 0, 0);
        check("idle_sop_error_err", int'(frame_err), 1);
        beat(1, 1, 1'b0, 1'b0, 2'b00, 0, 0);
        check("idle_stray_no_err", int'(frame_err), 0);
        beat(1, 1, 1'b1, 1'b0, 2'b00, 0, 0);
        beat(1, 1, 1'b0, 1'b0, 2'b10, 0, 0);
        check("capt_error_err", int'(frame_err), 1);
        beat(1, 1, 1'b0, 1'b1, 2'b00, 0, 0);
        check("after_capt_error_no_err", int'(frame_err), 0);
        check("after_capt_error_frame_rdy", int'(frame_rdy), 0);

        // Backpressure: src_valid held high while a frame is held
        good_frame(3, 9);
        src_valid = 1'b1;
        src_sop   = 1'b1;
        for (int c = 0; c < 6; c++) begin
            src_real = DW'($urandom);
            src_imag = DW'($urandom);
            step();
            check("hold_src_ready", int'(src_ready), 0);
        end
        src_valid = 1'b0;
        src_sop   = 1'b0;
        check("hold_frame_rdy", int'(frame_rdy), 1);
        check("hold_frame_exp", int'(frame_exp), 9);
        drain();

        // Reset during capture
        for (int k = 0; k < 4; k++) beat(k, k, k == 0, 1'b0, 2'b00, 11, 2 * k);
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_capt");
        pend.delete();
        step();
        Reset_n = 1'b1;
        step();
        good_frame(1, -1);
        drain();

        // Reset during readout
        good_frame(2, 6);
        read_n(3);
        step();
        Reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_hold");
        sb.delete();
        step();
        Reset_n = 1'b1;
        step();
        good_frame(4, -2);
        drain();

        repeat (3) step();
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
